// File: rtl/clock_divider_multi.sv
// Multi-channel programmable 50%-duty clock divider with a per-channel valid/ready reprogramming slot.
// Optional feature: define CLKDIV_SYNC_START_EN to add the sync_start phase-alignment input.
module clock_divider_multi #(
    parameter int N_CH         = 4,
    parameter int HALF_W       = 24,
    parameter int DEFAULT_HALF = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [$clog2(N_CH):0] cfg_ch,
    input  logic [HALF_W-1:0]     cfg_half,
`ifdef CLKDIV_SYNC_START_EN
    input  logic                  sync_start,
`endif
    output logic [N_CH-1:0]       clk_out,
    output logic [N_CH-1:0]       rise_pulse,
    output logic [N_CH-1:0]       running
);

    localparam int                CH_W       = $clog2(N_CH) + 1;
    localparam logic [HALF_W-1:0] HALF_ONE   = HALF_W'(1);
    localparam logic [HALF_W-1:0] HALF_RESET = HALF_W'(DEFAULT_HALF);

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUN_LOW  = 2'd1,
        ST_RUN_HIGH = 2'd2
    } state_t;

    localparam state_t STATE_RESET = (DEFAULT_HALF != 0) ? ST_RUN_LOW : ST_STOPPED;

    logic [N_CH-1:0] w_pend_vld;
    logic            w_sync;

`ifdef CLKDIV_SYNC_START_EN
    assign w_sync = sync_start;
`else
    assign w_sync = 1'b0;
`endif

    // Out-of-range channel numbers always see a free slot so the request is silently dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !w_pend_vld[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            state_t            r_state;
            logic [HALF_W-1:0] r_cnt;
            logic [HALF_W-1:0] r_active_half;
            logic [HALF_W-1:0] r_pend_half;
            logic              r_pend_vld;
            logic              r_clk;
            logic              r_rise;
            logic              w_accept;
            logic              w_last;

            assign w_accept = cfg_valid && cfg_ready && (cfg_ch == CH_W'(gi));
            assign w_last   = (r_cnt == r_active_half - HALF_ONE);

            always_ff @(posedge clk_in or negedge rst_n) begin
                if (!rst_n) begin
                    r_state       <= STATE_RESET;
                    r_cnt         <= '0;
                    r_active_half <= HALF_RESET;
                    r_pend_half   <= '0;
                    r_pend_vld    <= 1'b0;
                    r_clk         <= 1'b0;
                    r_rise        <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    // A slot can only be filled while empty, so it never collides with an apply below.
                    if (w_accept) begin
                        r_pend_vld  <= 1'b1;
                        r_pend_half <= cfg_half;
                    end
                    if (w_sync && (r_state != ST_STOPPED)) begin
                        r_cnt <= '0;
                        r_clk <= 1'b0;
                        if (r_pend_vld) begin
                            r_active_half <= r_pend_half;
                            r_pend_vld    <= 1'b0;
                            r_state       <= (r_pend_half == '0) ? ST_STOPPED : ST_RUN_LOW;
                        end else begin
                            r_state <= ST_RUN_LOW;
                        end
                    end else begin
                        case (r_state)
                            ST_STOPPED: begin
                                r_cnt <= '0;
                                r_clk <= 1'b0;
                                if (r_pend_vld) begin
                                    r_active_half <= r_pend_half;
                                    r_pend_vld    <= 1'b0;
                                    if (r_pend_half != '0) begin
                                        r_state <= ST_RUN_LOW;
                                    end
                                end
                            end
                            ST_RUN_LOW: begin
                                if (w_last) begin
                                    r_state <= ST_RUN_HIGH;
                                    r_clk   <= 1'b1;
                                    r_rise  <= 1'b1;
                                    r_cnt   <= '0;
                                end else begin
                                    r_cnt <= r_cnt + HALF_ONE;
                                end
                            end
                            ST_RUN_HIGH: begin
                                // End of a full period is the only glitch-free point to change the half.
                                if (w_last) begin
                                    r_clk <= 1'b0;
                                    r_cnt <= '0;
                                    if (r_pend_vld) begin
                                        r_active_half <= r_pend_half;
                                        r_pend_vld    <= 1'b0;
                                        r_state       <= (r_pend_half == '0) ? ST_STOPPED : ST_RUN_LOW;
                                    end else begin
                                        r_state <= ST_RUN_LOW;
                                    end
                                end else begin
                                    r_cnt <= r_cnt + HALF_ONE;
                                end
                            end
                            default: begin
                                r_state <= ST_STOPPED;
                                r_cnt   <= '0;
                                r_clk   <= 1'b0;
                            end
                        endcase
                    end
                end
            end

            assign w_pend_vld[gi] = r_pend_vld;
            assign clk_out[gi]    = r_clk;
            assign rise_pulse[gi] = r_rise;
            assign running[gi]    = (r_state == ST_RUN_LOW) || (r_state == ST_RUN_HIGH);
        end
    endgenerate

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: expected outputs are queued per clock cycle, a negedge monitor compares them.
module tb_clock_divider_multi;

    localparam int N_CH   = 4;
    localparam int HALF_W = 24;
    localparam int K_CLK  = 0;
    localparam int K_RISE = 1;
    localparam int K_RUN  = 2;
    localparam int K_RDY  = 3;

    logic                  clk_in;
    logic                  rst_n;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [$clog2(N_CH):0] cfg_ch;
    logic [HALF_W-1:0]     cfg_half;
`ifdef CLKDIV_SYNC_START_EN
    logic                  sync_start;
`endif
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       rise_pulse;
    logic [N_CH-1:0]       running;

    typedef struct {
        int cyc;
        int kind;
        int ch;
        int val;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   b0;
    int   b1;

    clock_divider_multi #(
        .N_CH(N_CH),
        .HALF_W(HALF_W),
        .DEFAULT_HALF(3)
    ) dut (
        .clk_in(clk_in),
        .rst_n(rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_half(cfg_half),
`ifdef CLKDIV_SYNC_START_EN
        .sync_start(sync_start),
`endif
        .clk_out(clk_out),
        .rise_pulse(rise_pulse),
        .running(running)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic string kname(input int kind);
        case (kind)
            K_CLK:   return "clk_out";
            K_RISE:  return "rise_pulse";
            K_RUN:   return "running";
            default: return "cfg_ready";
        endcase
    endfunction

    function automatic void push(input int c, input int kind, input int ch, input int v);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.ch   = ch;
        e.val  = v;
        sb.push_back(e);
    endfunction

    // Channel restarted in RUN_LOW with cnt=0 after relative edge s: high during odd multiples of h.
    function automatic void exp_wave(input int ch, input int base, input int s, input int h,
                                     input int from, input int to);
        for (int k = from; k <= to; k++) begin
            int d;
            int c;
            d = k - s;
            c = ((d / h) % 2 == 1) ? 1 : 0;
            push(base + k, K_CLK, ch, c);
            push(base + k, K_RISE, ch, (c == 1 && d % h == 0) ? 1 : 0);
            push(base + k, K_RUN, ch, 1);
        end
    endfunction

    always @(negedge clk_in) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                int got;
                case (sb[i].kind)
                    K_CLK:   got = int'(clk_out[sb[i].ch]);
                    K_RISE:  got = int'(rise_pulse[sb[i].ch]);
                    K_RUN:   got = int'(running[sb[i].ch]);
                    default: got = int'(cfg_ready);
                endcase
                checks++;
                if (got != sb[i].val) begin
                    errors++;
                    $display("FAIL %s ch%0d cyc %0d got %0d exp %0d",
                             kname(sb[i].kind), sb[i].ch, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic at_k(input int base, input int k);
        while (cyc < base + k) step();
    endtask

    task automatic drive(input logic v, input int ch, input int half);
        cfg_valid = v;
        cfg_ch    = ($clog2(N_CH) + 1)'(ch);
        cfg_half  = HALF_W'(half);
        if (v) $display("cfg request ch%0d half %0d at cyc %0d", ch, half, cyc);
    endtask

    int rdy_k [22] = '{3, 4, 5, 6, 7, 8, 11, 12, 14, 15, 16, 21, 22, 23, 24, 25, 26, 27, 31, 32, 39, 40};
    int rdy_v [22] = '{1, 0, 0, 1, 1, 0,  0,  1,  1,  0,  1,  1,  0,  0,  1,  0,  1,  0,  0,  1,  1,  1};

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_half  = '0;
`ifdef CLKDIV_SYNC_START_EN
        sync_start = 1'b0;
`endif
        step();
        step();
        for (int ch = 0; ch < N_CH; ch++) begin
            push(cyc, K_CLK, ch, 0);
            push(cyc, K_RISE, ch, 0);
            push(cyc, K_RUN, ch, 1);
        end
        push(cyc, K_RDY, 0, 1);
        step();
        rst_n = 1'b1;
        b0    = cyc;

        // ch0: half 3, then 4 applied at edge 24, then 6 applied at edge 32
        exp_wave(0, b0, 0, 3, 1, 23);
        exp_wave(0, b0, 24, 4, 24, 31);
        exp_wave(0, b0, 32, 6, 32, 39);
        // ch1: request during high phase; the high phase keeps 3, half 5 from edge 6
        exp_wave(1, b0, 0, 3, 1, 5);
        exp_wave(1, b0, 6, 5, 6, 39);
        // ch2: stopped at edge 12, restarted with half 2 at edge 16
        exp_wave(2, b0, 0, 3, 1, 11);
        for (int k = 12; k <= 15; k++) begin
            push(b0 + k, K_CLK, 2, 0);
            push(b0 + k, K_RISE, 2, 0);
            push(b0 + k, K_RUN, 2, 0);
        end
        exp_wave(2, b0, 16, 2, 16, 39);
        // ch3: untouched, also shows the cfg_ch=7 request has no effect
        exp_wave(3, b0, 0, 3, 1, 39);
        for (int i = 0; i < 22; i++) push(b0 + rdy_k[i], K_RDY, 0, rdy_v[i]);

        at_k(b0, 3);  drive(1'b1, 1, 5);
        at_k(b0, 4);  drive(1'b0, 1, 5);
        at_k(b0, 7);  drive(1'b1, 2, 0);
        at_k(b0, 8);  drive(1'b0, 2, 0);
        at_k(b0, 14); drive(1'b1, 2, 2);
        at_k(b0, 15); drive(1'b0, 2, 2);
        at_k(b0, 21); drive(1'b1, 0, 4);
        at_k(b0, 22); drive(1'b1, 0, 6);
        at_k(b0, 25); drive(1'b0, 0, 6);
        at_k(b0, 26); drive(1'b1, 7, 1);
        at_k(b0, 27); drive(1'b0, 0, 0);
        at_k(b0, 39); drive(1'b1, 3, 7);
        at_k(b0, 40); drive(1'b0, 3, 7);

        // Asynchronous reset in the middle of ch3's high phase, with its request still pending
        for (int ch = 0; ch < N_CH; ch++) begin
            push(cyc, K_CLK, ch, 0);
            push(cyc, K_RISE, ch, 0);
            push(cyc, K_RUN, ch, 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (clk_out !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset clk_out got %b exp 0000", clk_out);
        end
        step();
        step();
        rst_n = 1'b1;
        b1    = cyc;
        for (int ch = 0; ch < N_CH; ch++) exp_wave(ch, b1, 0, 3, 1, 13);
        push(b1 + 1, K_RDY, 3, 1);

        for (int i = 0; i < 200 && sb.size() != 0; i++) step();
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s ch%0d cyc %0d never checked exp %0d",
                     kname(sb[i].kind), sb[i].ch, sb[i].cyc, sb[i].val);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
